// File: rtl/t5_gprfx_if.sv
// Register-file port bundle: two fetch-side read ports, one writeback port,
// and the per-hart clear request with its busy flag.
interface t5_gprfx_if #(
  parameter int XLEN = 32,
  parameter int HW   = 2
);
  logic [HW-1:0]   fhart;
  logic [4:0]      rs1a;
  logic [4:0]      rs2a;
  logic [XLEN-1:0] rs1d;
  logic [XLEN-1:0] rs2d;
  logic [HW-1:0]   mhart;
  logic [4:0]      rd0a;
  logic [XLEN-1:0] rd0d;
  logic            mwre;
  logic            clrreq;
  logic [HW-1:0]   clrhart;
  logic            gbusy;

  modport master (
    output fhart, rs1a, rs2a, mhart, rd0a, rd0d, mwre, clrreq, clrhart,
    input  rs1d, rs2d, gbusy
  );

  modport slave (
    input  fhart, rs1a, rs2a, mhart, rd0a, rd0d, mwre, clrreq, clrhart,
    output rs1d, rs2d, gbusy
  );
endinterface

// File: rtl/t5_gprfx.sv
// Multi-hart GPR file: two registered read ports with write bypass, x0 forced
// to zero, and a clear sequencer that zeroes the file after reset or per hart.
module t5_gprfx_rport #(
  parameter int XLEN = 32,
  parameter int IW   = 7,
  parameter int AW   = 5
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic [IW-AW-1:0] hart,
  input  logic [4:0]      addr,
  output logic [IW-1:0]   idx,
  input  logic [XLEN-1:0] mdat,
  input  logic            we,
  input  logic [IW-1:0]   widx,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] dout
);
  assign idx = {hart, addr[AW-1:0]};

  always_ff @(posedge sclk) begin
    if (srst)                     dout <= '0;
    else if (addr[AW-1:0] == '0)  dout <= '0;
    else if (we && widx == idx)   dout <= wd;
    else                          dout <= mdat;
  end
endmodule

module t5_gprfx #(
  parameter int XLEN  = 32,
  parameter int HARTS = 4,
  parameter int NREG  = 32,
  localparam int HW   = $clog2(HARTS)
) (
  input  logic        sclk,
  input  logic        srst,
  t5_gprfx_if.slave   bus
);
  localparam int AW = (NREG == 16) ? 4 : 5;
  localparam int IW = HW + AW;
  localparam int NP = 2;

  localparam logic [1:0] S_CLRALL  = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_CLRHART = 2'd2;

  localparam logic [IW-1:0] LAST_ALL = '1;
  localparam logic [AW-1:0] LAST_REG = '1;

  logic [XLEN-1:0] mem [HARTS*NREG];

  logic [1:0]    state;
  logic [IW-1:0] cnt;
  logic [HW-1:0] lhart;

  logic            we;
  logic [IW-1:0]   widx;
  logic [XLEN-1:0] wd;

  logic [NP-1:0][4:0]      raddr;
  logic [NP-1:0][IW-1:0]   ridx;
  logic [NP-1:0][XLEN-1:0] rmem;
  logic [NP-1:0][XLEN-1:0] rout;

  assign bus.gbusy = (state != S_IDLE);

  // Clear-sequencer zero writes take priority; external writes only land when idle.
  always_comb begin
    we   = 1'b0;
    widx = '0;
    wd   = '0;
    if (!srst) begin
      if (state == S_CLRALL) begin
        we   = 1'b1;
        widx = cnt;
      end else if (state == S_CLRHART) begin
        we   = 1'b1;
        widx = {lhart, cnt[AW-1:0]};
      end else if (bus.mwre && bus.rd0a[AW-1:0] != '0) begin
        we   = 1'b1;
        widx = {bus.mhart, bus.rd0a[AW-1:0]};
        wd   = bus.rd0d;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (we) mem[widx] <= wd;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state <= S_CLRALL;
      cnt   <= '0;
      lhart <= '0;
    end else begin
      case (state)
        S_CLRALL: begin
          if (cnt == LAST_ALL) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.clrreq) begin
            lhart <= bus.clrhart;
            cnt   <= '0;
            state <= S_CLRHART;
          end
        end
        S_CLRHART: begin
          if (cnt[AW-1:0] == LAST_REG) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_CLRALL;
        end
      endcase
    end
  end

  assign raddr[0] = bus.rs1a;
  assign raddr[1] = bus.rs2a;

  for (genvar p = 0; p < NP; p++) begin : g_rp
    assign rmem[p] = mem[ridx[p]];
    t5_gprfx_rport #(.XLEN(XLEN), .IW(IW), .AW(AW)) u_rp (
      .sclk (sclk),
      .srst (srst),
      .hart (bus.fhart),
      .addr (raddr[p]),
      .idx  (ridx[p]),
      .mdat (rmem[p]),
      .we   (we),
      .widx (widx),
      .wd   (wd),
      .dout (rout[p])
    );
  end

  assign bus.rs1d = rout[0];
  assign bus.rs2d = rout[1];
endmodule

// File: tb/tb_t5_gprfx.sv
// Directed bench for t5_gprfx: default 4x32x32 instance plus a 2x16x64 instance.
module tb_t5_gprfx;
  logic sclk;
  logic srst;
  logic srst2;
  int   nc;
  int   nf;
  int   n;

  t5_gprfx_if #(.XLEN(32), .HW(2)) b1 ();
  t5_gprfx_if #(.XLEN(64), .HW(1)) b2 ();

  t5_gprfx #(.XLEN(32), .HARTS(4), .NREG(32)) u1 (.sclk(sclk), .srst(srst),  .bus(b1));
  t5_gprfx #(.XLEN(64), .HARTS(2), .NREG(16)) u2 (.sclk(sclk), .srst(srst2), .bus(b2));

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic wr1(input int h, input int a, input logic [31:0] d);
    b1.mhart = 2'(h); b1.rd0a = 5'(a); b1.rd0d = d; b1.mwre = 1'b1;
    @(negedge sclk);
    b1.mwre = 1'b0;
  endtask

  task automatic busy1();
    n = 0;
    while (b1.gbusy === 1'b1 && n < 1000) begin n++; @(negedge sclk); end
  endtask

  task automatic test_reset();
    @(negedge sclk);
    srst = 1'b1; b1.fhart = 2'd1; b1.rs1a = 5'd3; b1.rs2a = 5'd4;
    repeat (3) begin
      @(negedge sclk);
      nc++;
      if (b1.rs1d !== 32'h0 || b1.rs2d !== 32'h0 || b1.gbusy !== 1'b1) begin
        nf++;
        $display("FAIL reset_hold rs1d=%h rs2d=%h gbusy=%b expected 0/0/1", b1.rs1d, b1.rs2d, b1.gbusy);
      end
    end
    srst = 1'b0;
    busy1();
    nc++;
    if (n !== 128) begin nf++; $display("FAIL reset_busy cycles=%0d expected 128", n); end
    for (int h = 0; h < 4; h++)
      for (int a = 0; a < 32; a++) begin
        b1.fhart = 2'(h); b1.rs1a = 5'(a); b1.rs2a = 5'(31 - a);
        @(negedge sclk);
        nc++;
        if (b1.rs1d !== 32'h0 || b1.rs2d !== 32'h0) begin
          nf++;
          $display("FAIL reset_zero h=%0d a=%0d rs1d=%h rs2d=%h expected 0", h, a, b1.rs1d, b1.rs2d);
        end
      end
  endtask

  task automatic test_write_readback();
    wr1(2, 5, 32'hDEADBEEF);
    b1.fhart = 2'd2; b1.rs1a = 5'd5;
    @(negedge sclk);
    nc++;
    if (b1.rs1d !== 32'hDEADBEEF) begin nf++; $display("FAIL readback rs1d=%h expected deadbeef", b1.rs1d); end
    b1.fhart = 2'd1;
    @(negedge sclk);
    nc++;
    if (b1.rs1d !== 32'h0) begin nf++; $display("FAIL other_hart rs1d=%h expected 0", b1.rs1d); end
  endtask

  task automatic test_x0_bypass();
    wr1(1, 0, 32'h1234);
    for (int h = 0; h < 4; h++) begin
      b1.fhart = 2'(h); b1.rs1a = 5'd0; b1.rs2a = 5'd0;
      @(negedge sclk);
      nc++;
      if (b1.rs1d !== 32'h0 || b1.rs2d !== 32'h0) begin
        nf++; $display("FAIL x0_read h=%0d rs1d=%h rs2d=%h expected 0", h, b1.rs1d, b1.rs2d);
      end
    end
    b1.mhart = 2'd3; b1.rd0a = 5'd7; b1.rd0d = 32'hA5A5A5A5; b1.mwre = 1'b1;
    b1.fhart = 2'd3; b1.rs2a = 5'd7; b1.rs1a = 5'd8;
    @(negedge sclk);
    b1.mwre = 1'b0;
    nc++;
    if (b1.rs2d !== 32'hA5A5A5A5) begin nf++; $display("FAIL bypass rs2d=%h expected a5a5a5a5", b1.rs2d); end
    nc++;
    if (b1.rs1d !== 32'h0) begin nf++; $display("FAIL bypass_other rs1d=%h expected 0", b1.rs1d); end
    b1.fhart = 2'd2;
    @(negedge sclk);
    nc++;
    if (b1.rs2d !== 32'h0) begin nf++; $display("FAIL bypass_hart rs2d=%h expected 0", b1.rs2d); end
    b1.fhart = 2'd3;
    @(negedge sclk);
    nc++;
    if (b1.rs2d !== 32'hA5A5A5A5) begin nf++; $display("FAIL bypass_stored rs2d=%h expected a5a5a5a5", b1.rs2d); end
  endtask

  task automatic test_hart_clear();
    for (int h = 0; h < 4; h++) wr1(h, 9, 32'(17 * (h + 1)));
    b1.clrhart = 2'd1; b1.clrreq = 1'b1;
    @(negedge sclk);
    b1.clrreq = 1'b0;
    busy1();
    nc++;
    if (n !== 32) begin nf++; $display("FAIL clr_busy cycles=%0d expected 32", n); end
    for (int h = 0; h < 4; h++) begin
      b1.fhart = 2'(h); b1.rs1a = 5'd9;
      @(negedge sclk);
      nc++;
      if (b1.rs1d !== ((h == 1) ? 32'h0 : 32'(17 * (h + 1)))) begin
        nf++; $display("FAIL clr_data h=%0d rs1d=%h expected %h", h, b1.rs1d, (h == 1) ? 32'h0 : 32'(17 * (h + 1)));
      end
    end
  endtask

  task automatic test_busy_writes();
    wr1(0, 4, 32'h77);
    b1.clrhart = 2'd3; b1.clrreq = 1'b1;
    @(negedge sclk);
    b1.clrreq = 1'b0;
    n = 0;
    while (b1.gbusy === 1'b1 && n < 1000) begin
      n++;
      if (n == 3) begin
        b1.mhart = 2'd0; b1.rd0a = 5'd4; b1.rd0d = 32'h55; b1.mwre = 1'b1;
        b1.clrhart = 2'd0; b1.clrreq = 1'b1;
      end
      if (n == 4) begin b1.mwre = 1'b0; b1.clrreq = 1'b0; end
      @(negedge sclk);
    end
    b1.mwre = 1'b0; b1.clrreq = 1'b0;
    nc++;
    if (n !== 32) begin nf++; $display("FAIL busy_len cycles=%0d expected 32", n); end
    b1.fhart = 2'd0; b1.rs1a = 5'd4; b1.rs2a = 5'd9;
    @(negedge sclk);
    nc++;
    if (b1.rs1d !== 32'h77) begin nf++; $display("FAIL busy_drop rs1d=%h expected 77", b1.rs1d); end
    nc++;
    if (b1.rs2d !== 32'h11) begin nf++; $display("FAIL busy_noreq rs2d=%h expected 11", b1.rs2d); end
    b1.fhart = 2'd3;
    @(negedge sclk);
    nc++;
    if (b1.rs2d !== 32'h0) begin nf++; $display("FAIL busy_clr3 rs2d=%h expected 0", b1.rs2d); end
  endtask

  task automatic test_reset_mid_clear();
    b1.fhart = 2'd0; b1.rs1a = 5'd9; b1.rs2a = 5'd4;
    b1.clrhart = 2'd2; b1.clrreq = 1'b1;
    @(negedge sclk);
    b1.clrreq = 1'b0;
    repeat (9) @(negedge sclk);
    srst = 1'b1; b1.clrhart = 2'd0; b1.clrreq = 1'b1;
    @(negedge sclk);
    b1.clrreq = 1'b0;
    @(negedge sclk);
    nc++;
    if (b1.rs1d !== 32'h0 || b1.rs2d !== 32'h0 || b1.gbusy !== 1'b1) begin
      nf++; $display("FAIL midrst_hold rs1d=%h rs2d=%h gbusy=%b expected 0/0/1", b1.rs1d, b1.rs2d, b1.gbusy);
    end
    srst = 1'b0;
    busy1();
    nc++;
    if (n !== 128) begin nf++; $display("FAIL midrst_busy cycles=%0d expected 128", n); end
    @(negedge sclk);
    nc++;
    if (b1.rs1d !== 32'h0 || b1.rs2d !== 32'h0) begin
      nf++; $display("FAIL midrst_zero rs1d=%h rs2d=%h expected 0", b1.rs1d, b1.rs2d);
    end
  endtask

  task automatic test_small_cfg();
    @(negedge sclk);
    srst2 = 1'b0;
    n = 0;
    while (b2.gbusy === 1'b1 && n < 1000) begin n++; @(negedge sclk); end
    nc++;
    if (n !== 32) begin nf++; $display("FAIL small_rst_busy cycles=%0d expected 32", n); end
    b2.mhart = 1'b1; b2.rd0a = 5'd21; b2.rd0d = 64'h0123456789ABCDEF; b2.mwre = 1'b1;
    @(negedge sclk);
    b2.mwre = 1'b0;
    b2.fhart = 1'b1; b2.rs1a = 5'd5; b2.rs2a = 5'd21;
    @(negedge sclk);
    nc++;
    if (b2.rs1d !== 64'h0123456789ABCDEF || b2.rs2d !== 64'h0123456789ABCDEF) begin
      nf++; $display("FAIL small_rd rs1d=%h rs2d=%h expected 0123456789abcdef", b2.rs1d, b2.rs2d);
    end
    b2.fhart = 1'b0;
    @(negedge sclk);
    nc++;
    if (b2.rs1d !== 64'h0) begin nf++; $display("FAIL small_hart0 rs1d=%h expected 0", b2.rs1d); end
    b2.clrhart = 1'b1; b2.clrreq = 1'b1;
    @(negedge sclk);
    b2.clrreq = 1'b0;
    n = 0;
    while (b2.gbusy === 1'b1 && n < 1000) begin n++; @(negedge sclk); end
    nc++;
    if (n !== 16) begin nf++; $display("FAIL small_clr_busy cycles=%0d expected 16", n); end
    b2.fhart = 1'b1;
    @(negedge sclk);
    nc++;
    if (b2.rs1d !== 64'h0) begin nf++; $display("FAIL small_clr_data rs1d=%h expected 0", b2.rs1d); end
    b2.clrreq = 1'b1;
    @(negedge sclk);
    b2.clrreq = 1'b0;
    repeat (5) @(negedge sclk);
    srst2 = 1'b1;
    repeat (2) @(negedge sclk);
    srst2 = 1'b0;
    n = 0;
    while (b2.gbusy === 1'b1 && n < 1000) begin n++; @(negedge sclk); end
    nc++;
    if (n !== 32) begin nf++; $display("FAIL small_midrst_busy cycles=%0d expected 32", n); end
  endtask

  initial begin
    nc = 0; nf = 0; n = 0;
    srst = 1'b1; srst2 = 1'b1;
    b1.fhart = '0; b1.rs1a = '0; b1.rs2a = '0; b1.mhart = '0; b1.rd0a = '0;
    b1.rd0d = '0; b1.mwre = 1'b0; b1.clrreq = 1'b0; b1.clrhart = '0;
    b2.fhart = '0; b2.rs1a = '0; b2.rs2a = '0; b2.mhart = '0; b2.rd0a = '0;
    b2.rd0d = '0; b2.mwre = 1'b0; b2.clrreq = 1'b0; b2.clrhart = '0;
    test_reset();
    test_write_readback();
    test_x0_bypass();
    test_hart_clear();
    test_busy_writes();
    test_reset_mid_clear();
    test_small_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
